// File: rtl/rv32_mem_pkg.sv
// Shared encodings and helpers for the RV32 memory stage: access sizes,
// writeback-source selects and the load/store unit state machine.
package rv32_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] RS_MEM = 2'd0;
  localparam logic [1:0] RS_ALU = 2'd1;
  localparam logic [1:0] RS_PC4 = 2'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Size 3 is not a legal RV32 access, so it is reported like a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return offset[0];
      SZ_W:    return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: byte enables and replicated store
// data on the way out, lane extraction and sign/zero extension on the way in.
module mem_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_offset,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic        ext_bit;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    be    = 4'b0000;
    wdata = st_data;
    case (st_size)
      SZ_B: begin
        be    = 4'b0001 << st_offset;
        wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        be    = 4'b0011 << st_offset;
        wdata = {2{st_data[15:0]}};
      end
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign shifted = rdata >> {ld_offset, 3'b000};

  always_comb begin
    ld_data = shifted;
    ext_bit = 1'b0;
    case (ld_size)
      SZ_B: begin
        ext_bit = ~ld_unsigned & shifted[7];
        ld_data = {{24{ext_bit}}, shifted[7:0]};
      end
      SZ_H: begin
        ext_bit = ~ld_unsigned & shifted[15];
        ld_data = {{16{ext_bit}}, shifted[15:0]};
      end
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: single-outstanding req/ack data port, pipeline
// stall for the duration of each access, misalignment fault without bus use.
module mem_stage_lsu
  import rv32_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        mem_r_w,
  input  logic [1:0]  mem_access_size,
  input  logic        mem_load_unsigned,
  input  logic        mem_write_sel,
  input  logic [1:0]  reg_store_sel,
  input  logic [31:0] addr,
  input  logic [31:0] rs2_data,
  input  logic [31:0] w_bypass_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned
);

  lsu_state_e  state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_offset;
  logic        lat_unsigned;
  logic        lat_load;

  logic        access;
  logic        mis;
  logic        launch;
  logic [31:0] st_src;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] ld_fmt;

  assign access     = valid && (!mem_r_w || reg_store_sel == RS_MEM);
  assign mis        = is_misaligned(mem_access_size, addr[1:0]);
  assign launch     = (state == LSU_IDLE) && access && !mis;
  assign misaligned = (state == LSU_IDLE) && access && mis;
  assign stall      = launch || (state == LSU_REQ);
  assign st_src     = mem_write_sel ? w_bypass_data : rs2_data;

  mem_lane_align u_align (
    .st_size     (mem_access_size),
    .st_offset   (addr[1:0]),
    .st_data     (st_src),
    .be          (be_nxt),
    .wdata       (wdata_nxt),
    .ld_size     (lat_size),
    .ld_offset   (lat_offset),
    .ld_unsigned (lat_unsigned),
    .rdata       (dmem_rdata),
    .ld_data     (ld_fmt)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state      <= LSU_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (launch) begin
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_we    <= !mem_r_w;
            dmem_be    <= be_nxt;
            dmem_wdata <= wdata_nxt;
            dmem_req   <= 1'b1;
            state      <= LSU_REQ;
          end
        end
        LSU_REQ: begin
          if (dmem_ack) begin
            if (lat_load) load_data <= ld_fmt;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= LSU_DONE;
          end
        end
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

  // NOTE: lane info is deliberately not reset; it is only read in REQ, which
  // is always entered through a launch that writes it.
  always_ff @(posedge clk) begin
    if (launch) begin
      lat_size     <= mem_access_size;
      lat_offset   <= addr[1:0];
      lat_unsigned <= mem_load_unsigned;
      lat_load     <= mem_r_w;
    end
  end

endmodule
